// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM duty ramp controller.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    SETTLE
  } ramp_state_t;

  localparam int DUTY_MAX_DEF = 10;

  // Saturate a signed duty request into 0..max_val.
  function automatic int clamp_duty(input int val, input int max_val);
    if (val < 0) begin
      return 0;
    end else if (val > max_val) begin
      return max_val;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/period_tick_div.sv
// Divides PWM period_start pulses by DIV and emits a one-cycle step enable.
module period_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic clr,
  input  logic preset,
  output logic step_en
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Preset loads the last count so the very next tick produces a step.
  always_comb begin
    cnt_d   = cnt_q;
    step_en = tick && (cnt_q == LAST);
    if (preset) begin
      cnt_d = LAST;
    end else if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Ramps the pwm_counter duty input one step at a time toward a commanded target,
// changing only on period boundaries and spacing steps RAMP_DIV periods apart.
module pwm_duty_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W   = 4,
  parameter int DUTY_MAX = DUTY_MAX_DEF,
  parameter int RAMP_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              period_start,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              target_valid,
  input  logic [DUTY_W-1:0] target,
  output logic              target_ready,
  output logic [DUTY_W-1:0] duty_multiplier,
  output logic              busy,
  output logic              at_min,
  output logic              at_max
);

  ramp_state_t       state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W:0]   duty_ext;
  logic              load;
  int                load_val;
  logic              step_en;

  assign duty_ext = {1'b0, duty_q};

  period_tick_div #(
    .DIV(RAMP_DIV)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .tick   (period_start && (state_q == RAMP)),
    .clr    (state_q != RAMP),
    .preset (load && (state_d == RAMP)),
    .step_en(step_en)
  );

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    load     = 1'b0;
    load_val = 0;
    unique case (state_q)
      IDLE: begin
        // Command wins over buttons; both buttons at once cancel out.
        if (target_valid) begin
          load     = 1'b1;
          load_val = clamp_duty(int'({1'b0, target}), DUTY_MAX);
        end else if (btn_up && !btn_down) begin
          load     = 1'b1;
          load_val = clamp_duty(int'(duty_ext + (DUTY_W+1)'(1)), DUTY_MAX);
        end else if (btn_down && !btn_up) begin
          load     = 1'b1;
          load_val = clamp_duty(int'(duty_ext) - 1, DUTY_MAX);
        end
        if (load) begin
          target_d = DUTY_W'(load_val);
          if (target_d != duty_q) begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (step_en) begin
          duty_d = (target_q > duty_q) ? duty_q + DUTY_W'(1) : duty_q - DUTY_W'(1);
          if (duty_d == target_q) begin
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        // Hold one full period at the final duty before accepting new work.
        if (period_start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
    end
  end

  assign duty_multiplier = duty_q;
  assign target_ready    = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign at_min          = (duty_q == '0);
  assign at_max          = (duty_q == DUTY_W'(DUTY_MAX));

endmodule
